// File: rtl/config_pkg.sv
// Shared types, defaults and index decode for the configuration-image loader.
package config_pkg;

    localparam int CFG_WORD_W    = 32;
    localparam int CFG_NUM_WORDS = 40;
    localparam int CFG_IDX_W     = 6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_SETUP  = 3'd2,
        ST_STROBE = 3'd3,
        ST_HOLD   = 3'd4,
        ST_FIN    = 3'd5
    } state_e;

    // Indices at or above CFG_NUM_WORDS decode to all-zero.
    function automatic logic [CFG_NUM_WORDS-1:0] idx_to_onehot(input logic [CFG_IDX_W-1:0] idx);
        logic [CFG_NUM_WORDS-1:0] oh;
        oh = '0;
        for (int i = 0; i < CFG_NUM_WORDS; i++) begin
            oh[i] = (idx == CFG_IDX_W'(i));
        end
        return oh;
    endfunction

endpackage

// File: rtl/config_onehot_dec.sv
// Combinational bank-index to one-hot latch-enable decode.
module config_onehot_dec
    import config_pkg::*;
#(
    parameter int NUM_WORDS = CFG_NUM_WORDS,
    parameter int IDX_W     = CFG_IDX_W
) (
    input  logic [IDX_W-1:0]     idx,
    output logic [NUM_WORDS-1:0] onehot
);

    generate
        if (NUM_WORDS == CFG_NUM_WORDS && IDX_W == CFG_IDX_W) begin : g_pkg
            assign onehot = idx_to_onehot(idx);
        end else begin : g_loop
            always_comb begin
                // NOTE: default every output first so no path leaves it unassigned (no latch).
                onehot = '0;
                for (int i = 0; i < NUM_WORDS; i++) begin
                    onehot[i] = (idx == IDX_W'(i));
                end
            end
        end
    endgenerate

endmodule

// File: rtl/config_loader.sv
// Streams a configuration image into a level-sensitive latch array using a
// setup / strobe / hold sequence per word.
module config_loader
    import config_pkg::*;
#(
    parameter int WORD_W    = CFG_WORD_W,
    parameter int NUM_WORDS = CFG_NUM_WORDS,
    parameter int IDX_W     = CFG_IDX_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 io_start,
    input  logic                 io_abort,
    input  logic                 io_word_valid,
    input  logic [WORD_W-1:0]    io_word_bits,
    output logic                 io_word_ready,
    output logic [WORD_W-1:0]    io_d_out,
    output logic [NUM_WORDS-1:0] io_configs_en,
    output logic                 io_busy,
    output logic [IDX_W-1:0]     io_word_idx,
    output logic                 io_done,
    output logic                 io_aborted
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [WORD_W-1:0]    d_out_q, d_out_d;
    logic [NUM_WORDS-1:0] en_q, en_d;
    logic [NUM_WORDS-1:0] dec_onehot;
    logic                 abort_pend_q, abort_pend_d;

    config_onehot_dec #(
        .NUM_WORDS(NUM_WORDS),
        .IDX_W    (IDX_W)
    ) u_dec (
        .idx   (idx_q),
        .onehot(dec_onehot)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        d_out_d      = d_out_q;
        abort_pend_d = abort_pend_q;
        case (state_q)
            ST_IDLE: begin
                if (io_start) begin
                    state_d      = ST_WAIT;
                    idx_d        = '0;
                    abort_pend_d = 1'b0;
                end
            end
            ST_WAIT: begin
                // An abort beats a word offered in the same cycle; that word is dropped.
                if (io_abort) begin
                    state_d      = ST_FIN;
                    abort_pend_d = 1'b1;
                end else if (io_word_valid) begin
                    d_out_d = io_word_bits;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                abort_pend_d = abort_pend_q | io_abort;
                state_d      = ST_STROBE;
            end
            ST_STROBE: begin
                abort_pend_d = abort_pend_q | io_abort;
                state_d      = ST_HOLD;
            end
            ST_HOLD: begin
                if (abort_pend_q || io_abort) begin
                    abort_pend_d = 1'b1;
                    state_d      = ST_FIN;
                end else if (idx_q == LAST_IDX) begin
                    state_d = ST_FIN;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_WAIT;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Enable is registered, so it is high exactly while the state register holds STROBE.
        en_d = (state_d == ST_STROBE) ? dec_onehot : '0;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            d_out_q      <= '0;
            en_q         <= '0;
            abort_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            d_out_q      <= d_out_d;
            en_q         <= en_d;
            abort_pend_q <= abort_pend_d;
        end
    end

    assign io_word_ready = (state_q == ST_WAIT);
    assign io_busy       = (state_q != ST_IDLE);
    assign io_done       = (state_q == ST_FIN) && !abort_pend_q;
    assign io_aborted    = (state_q == ST_FIN) && abort_pend_q;
    assign io_d_out      = d_out_q;
    assign io_configs_en = en_q;
    assign io_word_idx   = idx_q;

endmodule

// File: tb/tb_config_loader.sv
// Self-checking bench for config_loader: directed scenarios followed by random
// traffic, all compared cycle by cycle against a transaction-level model.
module tb_config_loader;

    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 40;
    localparam int IDX_W     = 6;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 io_start;
    logic                 io_abort;
    logic                 io_word_valid;
    logic [WORD_W-1:0]    io_word_bits;
    logic                 io_word_ready;
    logic [WORD_W-1:0]    io_d_out;
    logic [NUM_WORDS-1:0] io_configs_en;
    logic                 io_busy;
    logic [IDX_W-1:0]     io_word_idx;
    logic                 io_done;
    logic                 io_aborted;

    always #5 clk = ~clk;

    config_loader #(
        .WORD_W   (WORD_W),
        .NUM_WORDS(NUM_WORDS),
        .IDX_W    (IDX_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .io_start     (io_start),
        .io_abort     (io_abort),
        .io_word_valid(io_word_valid),
        .io_word_bits (io_word_bits),
        .io_word_ready(io_word_ready),
        .io_d_out     (io_d_out),
        .io_configs_en(io_configs_en),
        .io_busy      (io_busy),
        .io_word_idx  (io_word_idx),
        .io_done      (io_done),
        .io_aborted   (io_aborted)
    );

    int errors = 0;
    int checks = 0;

    // Model: a load is "waiting" for a word, or m_since cycles past an accept
    // (1 = setup, 2 = strobe, 3 = hold), or in its single finishing cycle.
    bit                m_busy, m_wait, m_fin, m_fin_abort, m_pend;
    int                m_since, m_idx;
    logic [WORD_W-1:0] m_d;

    bit                   auto_feed;
    logic [NUM_WORDS-1:0] prev_en;
    logic [WORD_W-1:0]    prev_d;
    bit                   prev_reset;
    int                   cyc, start_cyc, done_lat, strobes;
    bit                   en8_seen, done_seen, aborted_seen, any_en_seen, reached;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        if (reset) begin
            m_busy = 0; m_wait = 0; m_fin = 0; m_fin_abort = 0; m_pend = 0;
            m_since = 0; m_idx = 0; m_d = '0;
        end else if (m_fin) begin
            m_fin  = 0;
            m_busy = 0;
        end else if (!m_busy) begin
            if (io_start) begin
                m_busy = 1; m_wait = 1; m_idx = 0; m_pend = 0;
            end
        end else if (m_wait) begin
            if (io_abort) begin
                m_wait = 0; m_fin = 1; m_fin_abort = 1;
            end else if (io_word_valid) begin
                m_d = io_word_bits; m_wait = 0; m_since = 1;
            end
        end else begin
            if (io_abort) m_pend = 1;
            if (m_since == 3) begin
                if (m_pend) begin
                    m_fin = 1; m_fin_abort = 1;
                end else if (m_idx == NUM_WORDS - 1) begin
                    m_fin = 1; m_fin_abort = 0;
                end else begin
                    m_idx++;
                    m_wait = 1;
                end
            end else begin
                m_since++;
            end
        end
    endtask

    function automatic bit m_strobing(input int idx);
        return m_busy && !m_wait && !m_fin && m_since == 2 && m_idx == idx;
    endfunction

    task automatic compare();
        logic [NUM_WORDS-1:0] exp_en;
        exp_en = (m_busy && !m_wait && !m_fin && m_since == 2) ? (NUM_WORDS'(1) << m_idx) : '0;
        check("busy",    64'(io_busy),       64'(m_busy));
        check("ready",   64'(io_word_ready), 64'(m_busy && m_wait));
        check("en",      64'(io_configs_en), 64'(exp_en));
        check("d_out",   64'(io_d_out),      64'(m_d));
        check("idx",     64'(io_word_idx),   64'(m_idx));
        check("done",    64'(io_done),       64'(m_fin && !m_fin_abort));
        check("aborted", 64'(io_aborted),    64'(m_fin && m_fin_abort));
        check("en_onehot0", 64'($onehot0(io_configs_en)), 64'(1));
        if (!prev_reset && io_d_out !== prev_d)
            check("d_change_near_strobe", 64'((prev_en | io_configs_en) == '0), 64'(1));
        if (auto_feed && io_configs_en != '0) begin
            int k = 0;
            for (int b = 0; b < NUM_WORDS; b++) if (io_configs_en[b]) k = b;
            check("strobe_data", 64'(io_d_out), 64'(32'h1000_0000 + 32'(k)));
        end
        if (io_configs_en != '0) strobes++;
        any_en_seen  |= (io_configs_en != '0);
        en8_seen     |= io_configs_en[8];
        aborted_seen |= io_aborted;
        if (io_done && !done_seen) done_lat = cyc - start_cyc + 1;
        done_seen    |= io_done;
    endtask

    task automatic step();
        if (auto_feed) io_word_bits = 32'h1000_0000 + 32'(m_idx);
        model_update();
        prev_en    = io_configs_en;
        prev_d     = io_d_out;
        prev_reset = reset;
        @(posedge clk);
        #1;
        cyc++;
        compare();
    endtask

    task automatic clear_flags();
        strobes = 0; en8_seen = 0; done_seen = 0; aborted_seen = 0;
        any_en_seen = 0; done_lat = 0; reached = 0;
    endtask

    task automatic start_load();
        start_cyc = cyc;
        io_start  = 1;
        step();
        io_start  = 0;
    endtask

    task automatic run_to_strobe(input int idx, input string tag);
        reached = m_strobing(idx);
        for (int n = 0; n < 400 && !reached; n++) begin
            step();
            reached = m_strobing(idx);
        end
        check(tag, 64'(reached), 64'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1; io_start = 0; io_abort = 0; io_word_valid = 0; io_word_bits = '0;
        auto_feed = 0; cyc = 0; start_cyc = 0;
        clear_flags();
        step();
        step();
        reset = 0;
        check("rst_en",   64'(io_configs_en), 64'(0));
        check("rst_dout", 64'(io_d_out),      64'(0));
        check("rst_busy", 64'(io_busy),       64'(0));
        step();

        // Abort alone in IDLE does nothing.
        io_abort = 1;
        step();
        io_abort = 0;
        check("idle_abort_busy",    64'(io_busy),    64'(0));
        check("idle_abort_aborted", 64'(io_aborted), 64'(0));

        // Full image with valid held high.
        clear_flags();
        auto_feed = 1; io_word_valid = 1;
        start_load();
        for (int n = 0; n < 300 && !done_seen; n++) step();
        check("full_done_seen",    64'(done_seen), 64'(1));
        check("full_done_latency", 64'(done_lat),  64'(4 * NUM_WORDS + 2));
        check("full_strobe_count", 64'(strobes),   64'(NUM_WORDS));
        step();
        check("full_busy_after", 64'(io_busy), 64'(0));

        // Back-pressure before word 3.
        clear_flags();
        start_load();
        for (int n = 0; n < 100 && !reached; n++) begin
            step();
            reached = m_busy && m_wait && m_idx == 3;
        end
        check("bp_reach_word3", 64'(reached), 64'(1));
        io_word_valid = 0;
        for (int n = 0; n < 5; n++) begin
            step();
            check("bp_ready", 64'(io_word_ready), 64'(1));
            check("bp_en",    64'(io_configs_en), 64'(0));
            check("bp_idx",   64'(io_word_idx),   64'(3));
            check("bp_dout",  64'(io_d_out),      64'(32'h1000_0002));
        end
        io_word_valid = 1;
        for (int n = 0; n < 300 && !done_seen; n++) step();
        check("bp_done_seen",    64'(done_seen), 64'(1));
        check("bp_strobe_count", 64'(strobes),   64'(NUM_WORDS));

        // Abort during the strobe of word 7.
        step();
        clear_flags();
        start_load();
        run_to_strobe(7, "ab_strobe_reach7");
        check("ab_strobe_en7", 64'(io_configs_en[7]), 64'(1));
        io_abort = 1;
        step();
        io_abort = 0;
        check("ab_strobe_hold_en",      64'(io_configs_en), 64'(0));
        check("ab_strobe_hold_aborted", 64'(io_aborted),    64'(0));
        step();
        check("ab_strobe_aborted", 64'(io_aborted), 64'(1));
        for (int n = 0; n < 12; n++) step();
        check("ab_strobe_no_en8",  64'(en8_seen),  64'(0));
        check("ab_strobe_no_done", 64'(done_seen), 64'(0));

        // Abort while waiting for word 0; the offered word is dropped.
        clear_flags();
        io_word_valid = 0;
        start_load();
        auto_feed = 0;
        io_word_bits = 32'hDEAD_BEEF; io_word_valid = 1; io_abort = 1;
        step();
        io_abort = 0; io_word_valid = 0;
        check("ab_wait_aborted", 64'(io_aborted), 64'(1));
        check("ab_wait_dout",    64'(io_d_out),   64'(32'h1000_0007));
        step();
        check("ab_wait_busy",  64'(io_busy),     64'(0));
        check("ab_wait_no_en", 64'(any_en_seen), 64'(0));

        // Reset during the strobe of word 12, then start+abort together.
        clear_flags();
        auto_feed = 1; io_word_valid = 1;
        start_load();
        run_to_strobe(12, "rst_mid_reach12");
        reset = 1;
        step();
        reset = 0;
        check("rst_mid_en",   64'(io_configs_en), 64'(0));
        check("rst_mid_dout", 64'(io_d_out),      64'(0));
        check("rst_mid_busy", 64'(io_busy),       64'(0));
        io_abort = 1;
        start_load();
        io_abort = 0;
        check("restart_busy", 64'(io_busy),     64'(1));
        check("restart_idx",  64'(io_word_idx), 64'(0));
        run_to_strobe(0, "restart_reach0");
        check("restart_en0", 64'(io_configs_en), 64'(1));

        // Random traffic, including starts while busy and rare resets.
        auto_feed = 0;
        for (int n = 0; n < 4000; n++) begin
            io_word_valid = ($urandom_range(0, 9) < 7);
            io_word_bits  = $urandom();
            io_start      = ($urandom_range(0, 19) == 0);
            io_abort      = ($urandom_range(0, 149) == 0);
            reset         = ($urandom_range(0, 999) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/config_loader.md
Name: config_loader

Overview:
- Sequencer that streams a full configuration image, NUM_WORDS words of WORD_W bits, into the tile's configuration latch array.
- Accepts words over a valid/ready stream and drives the array's shared data bus and one-hot per-word latch enables.
- Enforces a setup / strobe / hold discipline, so that each level-sensitive latch bank captures exactly one stable word.
- Sits between the configuration shift/bus interface and the latch array in each lut_tile.

Parameters:
- WORD_W, 32: width of one configuration word and of the latch data bus.
- NUM_WORDS, 40: number of latch banks, i.e. words per full image.
- IDX_W, 6: index width, ceil(log2(NUM_WORDS)); must hold NUM_WORDS-1.

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- io_start, input, 1: begin loading an image; honoured only in IDLE.
- io_abort, input, 1: terminate the load early.
- io_word_valid, input, 1: a configuration word is offered.
- io_word_bits, input, WORD_W: the offered word.
- io_word_ready, output, 1: the loader accepts the word this cycle.
- io_d_out, output, WORD_W: registered data bus to the latch array.
- io_configs_en, output, NUM_WORDS: registered one-hot latch enables.
- io_busy, output, 1: high in every state except IDLE.
- io_word_idx, output, IDX_W: index of the bank currently being loaded.
- io_done, output, 1: one-cycle pulse after the last word's hold cycle.
- io_aborted, output, 1: one-cycle pulse when an abort completes.

Behaviour:
- Reset values: state=IDLE; io_d_out=0; io_configs_en=0; io_word_idx=0; io_word_ready, io_busy, io_done and io_aborted all 0.
- Reset is also honoured mid-load. io_configs_en drops to 0 on the next edge; a truncated strobe is acceptable only under reset.
- States: IDLE, WAIT, SETUP, STROBE, HOLD, FIN.
- IDLE:
  - io_start=1 -> WAIT, io_word_idx=0.
  - io_abort alone -> no effect.
- WAIT:
  - io_word_ready=1, combinational from state only; it must not depend on io_word_valid.
  - On valid&&ready, io_d_out <= io_word_bits and the state moves to SETUP.
  - The word is accepted on that edge.
- SETUP: io_configs_en=0; io_d_out stable. Next state STROBE.
- STROBE:
  - io_configs_en has exactly bit io_word_idx set, for exactly one cycle.
  - io_d_out stays unchanged. Next state HOLD.
- HOLD:
  - io_configs_en=0; io_d_out stays unchanged, giving one cycle of hold after the enable falls.
  - If abort is pending -> FIN(abort).
  - Else if io_word_idx==NUM_WORDS-1 -> FIN(done).
  - Else io_word_idx++ and -> WAIT.
- FIN:
  - Exactly one of io_done or io_aborted is high for this single cycle. Next state IDLE.
  - io_word_idx is not cleared; it keeps the last index.
- Throughput: one word per 4 cycles when valid is held high. Accept-to-enable latency is 2 cycles; the enable is registered.
- io_d_out changes only on a WAIT accept. No enable bit is ever high in the cycle before or after a data change.
- Abort handling:
  - In WAIT: go directly to FIN(abort); the pending word is not accepted.
  - In SETUP or STROBE: set abort_pend and let the sequence complete through HOLD. The current bank is written and its strobe is never truncated.
  - In HOLD: treated as pending, and the state goes to FIN(abort).
  - In FIN or IDLE: ignored.
- io_start while busy: ignored.
- Simultaneous io_start and io_abort in IDLE: the start wins.
- No enable bit is ever driven at or above NUM_WORDS. io_word_idx never wraps; FIN is reached first.

Decomposition:
- Shared package config_pkg holds:
  - state enum {IDLE, WAIT, SETUP, STROBE, HOLD, FIN};
  - WORD_W and NUM_WORDS defaults;
  - an idx-to-one-hot decode function.
- One sub-module is natural: config_onehot_dec (IDX_W -> NUM_WORDS, combinational). The loader registers its output.

Test Plan:
- Full load: reset, pulse io_start, stream words 32'h1000_0000+i for i=0..39 with valid held high.
  - Required: 40 one-cycle strobes, en[i] coinciding with io_d_out=32'h1000_0000+i.
  - io_done pulses at cycle 4*40+2 after start; io_busy then drops.
- Back-pressure: drop valid for 5 cycles before word 3.
  - Required: state stays WAIT, io_configs_en=0, io_word_idx=3, io_d_out holds word 2.
  - Loading resumes correctly.
- Abort in STROBE at word 7.
  - Required: en[7] completes its full cycle, a HOLD cycle follows, then an io_aborted pulse.
  - en[8] is never asserted and io_done stays 0.
- Abort in WAIT at word 0: io_aborted pulses 1 cycle later, no enable is ever asserted, and the offered word is not acked.
- Reset mid-load during STROBE at word 12:
  - next cycle io_configs_en=0, io_d_out=0, io_busy=0;
  - a new io_start then loads from index 0.
- Protocol checker for every run:
  - io_configs_en is one-hot or zero;
  - io_d_out is stable in the cycles before, during and after every strobe;
  - io_start while busy has no effect.
